// File: rtl/mmio_id_tracker.sv
// mmio_id_tracker: AXI-lite MMIO shim from the OFS host-channel port (with IDs)
// to the Fletcher AxiTop slave port (no IDs). Accepted AR/AW IDs are queued in
// per-direction in-order FIFOs and replayed on the matching R/B responses.
module mmio_id_tracker #(
    parameter int ID_W   = 9,
    parameter int ADDR_W = 18,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    // Host-side (upstream) read channels
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ID_W-1:0]   s_rid,
    output logic [63:0]       s_rdata,
    output logic [1:0]        s_rresp,

    // Host-side (upstream) write channels
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ID_W-1:0]   s_awid,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [63:0]       s_wdata,
    input  logic [7:0]        s_wstrb,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,

    // AxiTop-side read channels
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [31:0]       m_araddr,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [63:0]       m_rdata,
    input  logic [1:0]        m_rresp,

    // AxiTop-side write channels
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_awaddr,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [63:0]       m_wdata,
    output logic [7:0]        m_wstrb,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [1:0]        m_bresp,

    output logic              err_orphan
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [ID_W-1:0]  rmem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic             r_full, r_empty, r_push, r_pop;

    logic [ID_W-1:0]  wmem [DEPTH];
    logic [PTR_W-1:0] w_wr_ptr, w_rd_ptr;
    logic             w_full, w_empty, w_push, w_pop;

    assign r_empty = (r_wr_ptr == r_rd_ptr);
    assign r_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (w_wr_ptr == w_rd_ptr);
    assign w_full  = (w_wr_ptr[AW] != w_rd_ptr[AW]) &&
                     (w_wr_ptr[AW-1:0] == w_rd_ptr[AW-1:0]);

    // Handshakes are qualified by reset_n so every valid/ready drops the
    // instant reset asserts, without waiting for a clock edge. Ready on AR/AW
    // uses the pre-pop full flag so there is no path from rready/bready.
    assign m_arvalid = reset_n & s_arvalid & ~r_full;
    assign s_arready = reset_n & m_arready & ~r_full;
    assign s_rvalid  = reset_n & m_rvalid  & ~r_empty;
    assign m_rready  = reset_n & s_rready  & ~r_empty;

    assign m_awvalid = reset_n & s_awvalid & ~w_full;
    assign s_awready = reset_n & m_awready & ~w_full;
    assign s_bvalid  = reset_n & m_bvalid  & ~w_empty;
    assign m_bready  = reset_n & s_bready  & ~w_empty;

    // Write data is not tied to the ID queue; AxiTop orders W against AW.
    assign m_wvalid  = reset_n & s_wvalid;
    assign s_wready  = reset_n & m_wready;
    assign m_wdata   = s_wdata;
    assign m_wstrb   = s_wstrb;

    assign m_araddr  = {{(32-ADDR_W){1'b0}}, s_araddr};
    assign m_awaddr  = {{(32-ADDR_W){1'b0}}, s_awaddr};
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_bresp   = m_bresp;

    assign r_push = s_arvalid & s_arready;
    assign r_pop  = s_rvalid  & s_rready;
    assign w_push = s_awvalid & s_awready;
    assign w_pop  = s_bvalid  & s_bready;

    // Head of queue falls through directly; an empty queue reports ID 0.
    assign s_rid = r_empty ? '0 : rmem[r_rd_ptr[AW-1:0]];
    assign s_bid = w_empty ? '0 : wmem[w_rd_ptr[AW-1:0]];

    // Read-ID queue: push on AR acceptance, pop on R completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rmem[i] <= '0;
            end
        end else begin
            if (r_push) begin
                rmem[r_wr_ptr[AW-1:0]] <= s_arid;
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (r_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Write-ID queue: push on AW acceptance, pop on B completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_wr_ptr <= '0;
            w_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                wmem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                wmem[w_wr_ptr[AW-1:0]] <= s_awid;
                w_wr_ptr <= w_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                w_rd_ptr <= w_rd_ptr + PTR_ONE;
            end
        end
    end

    // Sticky flag for a response offered while no ID is waiting for it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_orphan <= 1'b0;
        end else if ((m_rvalid & r_empty) | (m_bvalid & w_empty)) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mmio_id_tracker.sv
// tb_mmio_id_tracker: table-driven directed bench for mmio_id_tracker, with
// hand-written sequences for reset, orphan responses and mid-flight reset.
module tb_mmio_id_tracker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_arvalid, s_arready;
    logic [8:0]  s_arid;
    logic [17:0] s_araddr;
    logic        s_rvalid, s_rready;
    logic [8:0]  s_rid;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_awvalid, s_awready;
    logic [8:0]  s_awid;
    logic [17:0] s_awaddr;
    logic        s_wvalid, s_wready;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [8:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic        m_rvalid, m_rready;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_awvalid, m_awready;
    logic [31:0] m_awaddr;
    logic        m_wvalid, m_wready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_bvalid, m_bready;
    logic [1:0]  m_bresp;
    logic        err_orphan;

    int total_checks = 0;
    int bad_checks   = 0;

    typedef struct {
        logic        arv;
        logic [8:0]  arid;
        logic [17:0] araddr;
        logic        rv;
        logic        rr;
        logic [63:0] rdata;
        logic        awv;
        logic [8:0]  awid;
        logic [17:0] awaddr;
        logic        bv;
        logic        br;
        logic [1:0]  bresp;
        logic        e_arr;
        logic        e_rv;
        logic        e_mrr;
        logic [8:0]  e_rid;
        logic        e_awr;
        logic        e_bv;
        logic        e_mbr;
        logic [8:0]  e_bid;
    } vec_t;

    vec_t vecs[$];

    mmio_id_tracker #(.ID_W(9), .ADDR_W(18), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .err_orphan(err_orphan)
    );

    // 10 ns clock; posedges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Hard stop so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(
        input logic arv, input logic [8:0] arid, input logic [17:0] araddr,
        input logic rv, input logic rr, input logic [63:0] rdata,
        input logic awv, input logic [8:0] awid, input logic [17:0] awaddr,
        input logic bv, input logic br, input logic [1:0] bresp,
        input logic e_arr, input logic e_rv, input logic e_mrr, input logic [8:0] e_rid,
        input logic e_awr, input logic e_bv, input logic e_mbr, input logic [8:0] e_bid);
        vec_t v;
        v.arv = arv; v.arid = arid; v.araddr = araddr;
        v.rv = rv; v.rr = rr; v.rdata = rdata;
        v.awv = awv; v.awid = awid; v.awaddr = awaddr;
        v.bv = bv; v.br = br; v.bresp = bresp;
        v.e_arr = e_arr; v.e_rv = e_rv; v.e_mrr = e_mrr; v.e_rid = e_rid;
        v.e_awr = e_awr; v.e_bv = e_bv; v.e_mbr = e_mbr; v.e_bid = e_bid;
        vecs.push_back(v);
    endfunction

    task automatic apply_stimulus(input vec_t v);
        s_arvalid = v.arv;  s_arid = v.arid;  s_araddr = v.araddr;
        m_arready = 1'b1;
        m_rvalid  = v.rv;   s_rready = v.rr;  m_rdata = v.rdata;  m_rresp = v.bresp;
        s_awvalid = v.awv;  s_awid = v.awid;  s_awaddr = v.awaddr;
        m_awready = 1'b1;
        s_wvalid  = v.awv;  m_wready = 1'b1;
        s_wdata   = 64'hA5A5_0000_0000_0000 | 64'(v.awid);
        s_wstrb   = v.awv ? 8'hFF : 8'h00;
        m_bvalid  = v.bv;   s_bready = v.br;  m_bresp = v.bresp;
    endtask

    task automatic drive_idle();
        s_arvalid = 0; s_arid = '0; s_araddr = '0; m_arready = 0;
        m_rvalid = 0; s_rready = 0; m_rdata = '0; m_rresp = '0;
        s_awvalid = 0; s_awid = '0; s_awaddr = '0; m_awready = 0;
        s_wvalid = 0; m_wready = 0; s_wdata = '0; s_wstrb = '0;
        m_bvalid = 0; s_bready = 0; m_bresp = '0;
    endtask

    initial begin
        // Expected table (DEPTH=4). Columns:
        // arv arid araddr rv rr rdata | awv awid awaddr bv br bresp | e_arr e_rv e_mrr e_rid | e_awr e_bv e_mbr e_bid
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h000);
        add_vec(1, 9'h1A5, 18'h00040, 0, 0, 64'h0, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h000);
        add_vec(0, 9'h000, 18'h00000, 0, 1, 64'h0, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 0, 1, 9'h1A5, 1, 0, 0, 9'h000);
        add_vec(0, 9'h000, 18'h00000, 0, 1, 64'h0, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 0, 1, 9'h1A5, 1, 0, 0, 9'h000);
        add_vec(0, 9'h000, 18'h00000, 1, 1, 64'hDEADBEEF_00000001, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 1, 1, 9'h1A5, 1, 0, 0, 9'h000);
        add_vec(0, 9'h000, 18'h00000, 0, 1, 64'h0, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h000);
        // fill the read queue with ids 1..4, then id 5 must stall until a pop
        add_vec(1, 9'h001, 18'h00100, 0, 0, 64'h0, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h000);
        add_vec(1, 9'h002, 18'h00108, 0, 0, 64'h0, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 0, 0, 9'h001, 1, 0, 0, 9'h000);
        add_vec(1, 9'h003, 18'h00110, 0, 0, 64'h0, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 0, 0, 9'h001, 1, 0, 0, 9'h000);
        add_vec(1, 9'h004, 18'h00118, 0, 0, 64'h0, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 0, 0, 9'h001, 1, 0, 0, 9'h000);
        add_vec(1, 9'h005, 18'h00120, 0, 0, 64'h0, 0, 9'h000, 18'h0, 0, 0, 2'd0, 0, 0, 0, 9'h001, 1, 0, 0, 9'h000);
        add_vec(1, 9'h005, 18'h00120, 1, 1, 64'h11, 0, 9'h000, 18'h0, 0, 0, 2'd0, 0, 1, 1, 9'h001, 1, 0, 0, 9'h000);
        add_vec(1, 9'h005, 18'h00120, 1, 1, 64'h22, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 1, 1, 9'h002, 1, 0, 0, 9'h000);
        add_vec(0, 9'h000, 18'h00000, 1, 1, 64'h33, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 1, 1, 9'h003, 1, 0, 0, 9'h000);
        add_vec(0, 9'h000, 18'h00000, 1, 1, 64'h44, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 1, 1, 9'h004, 1, 0, 0, 9'h000);
        add_vec(0, 9'h000, 18'h00000, 1, 1, 64'h55, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 1, 1, 9'h005, 1, 0, 0, 9'h000);
        add_vec(0, 9'h000, 18'h00000, 0, 1, 64'h0, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h000);
        // single write at the top of the address range
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 1, 9'h0FF, 18'h3FFF8, 0, 0, 2'd0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h000);
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 0, 9'h000, 18'h0, 1, 1, 2'd0, 1, 0, 0, 9'h000, 1, 1, 1, 9'h0FF);
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 0, 9'h000, 18'h0, 0, 1, 2'd0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h000);
        // read id 7 and write id 9 issued and completed together
        add_vec(1, 9'h007, 18'h00010, 0, 0, 64'h0, 1, 9'h009, 18'h00020, 0, 0, 2'd0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h000);
        add_vec(0, 9'h000, 18'h00000, 1, 1, 64'h01234567_89ABCDEF, 0, 9'h000, 18'h0, 1, 1, 2'd2, 1, 1, 1, 9'h007, 1, 1, 1, 9'h009);
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 0, 9'h000, 18'h0, 0, 0, 2'd0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h000);
        // fill the write queue, stall the fifth AW, drain in order
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 1, 9'h010, 18'h00200, 0, 0, 2'd0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h000);
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 1, 9'h011, 18'h00208, 0, 0, 2'd0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h010);
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 1, 9'h012, 18'h00210, 0, 0, 2'd0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h010);
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 1, 9'h013, 18'h00218, 0, 0, 2'd0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h010);
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 1, 9'h014, 18'h00220, 0, 0, 2'd0, 1, 0, 0, 9'h000, 0, 0, 0, 9'h010);
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 0, 9'h000, 18'h0, 1, 1, 2'd1, 1, 0, 0, 9'h000, 0, 1, 1, 9'h010);
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 0, 9'h000, 18'h0, 1, 1, 2'd0, 1, 0, 0, 9'h000, 1, 1, 1, 9'h011);
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 0, 9'h000, 18'h0, 1, 1, 2'd0, 1, 0, 0, 9'h000, 1, 1, 1, 9'h012);
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 0, 9'h000, 18'h0, 1, 1, 2'd0, 1, 0, 0, 9'h000, 1, 1, 1, 9'h013);
        add_vec(0, 9'h000, 18'h00000, 0, 0, 64'h0, 0, 9'h000, 18'h0, 0, 1, 2'd0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h000);

        // Reset state: every input asserted, outputs must still be quiet.
        reset_n = 1'b0;
        drive_idle();
        s_arvalid = 1; m_arready = 1; m_rvalid = 1; s_rready = 1;
        s_awvalid = 1; m_awready = 1; s_wvalid = 1; m_wready = 1;
        m_bvalid = 1; s_bready = 1;
        #2;
        check_output("rst s_arready", 64'(s_arready), 64'h0);
        check_output("rst m_arvalid", 64'(m_arvalid), 64'h0);
        check_output("rst s_rvalid",  64'(s_rvalid),  64'h0);
        check_output("rst m_rready",  64'(m_rready),  64'h0);
        check_output("rst s_awready", 64'(s_awready), 64'h0);
        check_output("rst m_awvalid", 64'(m_awvalid), 64'h0);
        check_output("rst m_wvalid",  64'(m_wvalid),  64'h0);
        check_output("rst s_wready",  64'(s_wready),  64'h0);
        check_output("rst s_bvalid",  64'(s_bvalid),  64'h0);
        check_output("rst m_bready",  64'(m_bready),  64'h0);
        check_output("rst s_rid",     64'(s_rid),     64'h0);
        check_output("rst s_bid",     64'(s_bid),     64'h0);
        check_output("rst err_orphan", 64'(err_orphan), 64'h0);
        drive_idle();
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Table-driven phase: drive after negedge, sample 2 ns later, then clock.
        foreach (vecs[i]) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            #2;
            check_output($sformatf("v%0d s_arready", i), 64'(s_arready), 64'(vecs[i].e_arr));
            check_output($sformatf("v%0d m_arvalid", i), 64'(m_arvalid), 64'(vecs[i].arv & vecs[i].e_arr));
            check_output($sformatf("v%0d m_araddr", i),  64'(m_araddr),  64'(vecs[i].araddr));
            check_output($sformatf("v%0d s_rvalid", i),  64'(s_rvalid),  64'(vecs[i].e_rv));
            check_output($sformatf("v%0d m_rready", i),  64'(m_rready),  64'(vecs[i].e_mrr));
            check_output($sformatf("v%0d s_rid", i),     64'(s_rid),     64'(vecs[i].e_rid));
            check_output($sformatf("v%0d s_rdata", i),   s_rdata,        vecs[i].rdata);
            check_output($sformatf("v%0d s_rresp", i),   64'(s_rresp),   64'(vecs[i].bresp));
            check_output($sformatf("v%0d s_awready", i), 64'(s_awready), 64'(vecs[i].e_awr));
            check_output($sformatf("v%0d m_awvalid", i), 64'(m_awvalid), 64'(vecs[i].awv & vecs[i].e_awr));
            check_output($sformatf("v%0d m_awaddr", i),  64'(m_awaddr),  64'(vecs[i].awaddr));
            check_output($sformatf("v%0d m_wvalid", i),  64'(m_wvalid),  64'(vecs[i].awv));
            check_output($sformatf("v%0d s_wready", i),  64'(s_wready),  64'h1);
            check_output($sformatf("v%0d m_wstrb", i),   64'(m_wstrb),   vecs[i].awv ? 64'hFF : 64'h0);
            check_output($sformatf("v%0d m_wdata", i),   m_wdata,        64'hA5A5_0000_0000_0000 | 64'(vecs[i].awid));
            check_output($sformatf("v%0d s_bvalid", i),  64'(s_bvalid),  64'(vecs[i].e_bv));
            check_output($sformatf("v%0d m_bready", i),  64'(m_bready),  64'(vecs[i].e_mbr));
            check_output($sformatf("v%0d s_bid", i),     64'(s_bid),     64'(vecs[i].e_bid));
            check_output($sformatf("v%0d s_bresp", i),   64'(s_bresp),   64'(vecs[i].bresp));
            check_output($sformatf("v%0d err_orphan", i), 64'(err_orphan), 64'h0);
            @(posedge clk);
        end

        // Orphan read response with an empty queue: held off, sticky error.
        @(negedge clk);
        drive_idle();
        m_rvalid = 1; s_rready = 1;
        #2;
        check_output("orphan s_rvalid", 64'(s_rvalid), 64'h0);
        check_output("orphan m_rready", 64'(m_rready), 64'h0);
        check_output("orphan err before edge", 64'(err_orphan), 64'h0);
        @(negedge clk);
        m_rvalid = 0;
        #2;
        check_output("orphan err after edge", 64'(err_orphan), 64'h1);
        repeat (100) @(posedge clk);
        #2;
        check_output("orphan err sticky", 64'(err_orphan), 64'h1);

        // Reset mid-flight with two reads outstanding.
        @(negedge clk);
        drive_idle();
        m_arready = 1; s_arvalid = 1; s_arid = 9'h011; s_araddr = 18'h00300;
        @(negedge clk);
        s_arid = 9'h022; s_araddr = 18'h00308;
        @(negedge clk);
        s_arvalid = 1; s_arid = 9'h033;
        m_rvalid = 1; s_rready = 1;
        s_awvalid = 1; m_awready = 1; s_wvalid = 1; m_wready = 1;
        #2;
        check_output("flight s_rvalid", 64'(s_rvalid), 64'h1);
        check_output("flight s_rid", 64'(s_rid), 64'h011);
        #1 reset_n = 1'b0;
        #1;
        check_output("async s_rvalid",  64'(s_rvalid),  64'h0);
        check_output("async m_rready",  64'(m_rready),  64'h0);
        check_output("async s_arready", 64'(s_arready), 64'h0);
        check_output("async m_arvalid", 64'(m_arvalid), 64'h0);
        check_output("async s_awready", 64'(s_awready), 64'h0);
        check_output("async m_wvalid",  64'(m_wvalid),  64'h0);
        check_output("async s_rid",     64'(s_rid),     64'h0);
        check_output("async err_orphan", 64'(err_orphan), 64'h0);
        drive_idle();
        s_rready = 1;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        #2;
        check_output("post-rst err_orphan", 64'(err_orphan), 64'h0);
        check_output("post-rst m_rready", 64'(m_rready), 64'h0);
        check_output("post-rst s_rid", 64'(s_rid), 64'h0);
        @(negedge clk);
        m_rvalid = 1;
        #2;
        check_output("post-rst orphan s_rvalid", 64'(s_rvalid), 64'h0);
        @(negedge clk);
        m_rvalid = 0;
        #2;
        check_output("post-rst orphan err", 64'(err_orphan), 64'h1);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
